// File: rtl/seq_detector_moore_pkg.sv
// Shared types and limits for the parametrised Moore serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ARMED = 2'd1,
        MATCH = 2'd2
    } seq_det_state_t;

    localparam int SEQ_DET_PAT_W_MIN = 2;
    localparam int SEQ_DET_PAT_W_MAX = 16;

endpackage

// File: rtl/seq_detector_moore_if.sv
// Serial bit stream, pattern reload and match signalling between a bit source and the detector.
interface seq_detector_moore_if #(
    parameter int PAT_W = 3
);
    logic             in_valid;
    logic             x;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             match;
    logic [PAT_W-1:0] pattern_q;

    modport master (
        output in_valid, x, pat_load, pat_in,
        input  match, pattern_q
    );

    modport slave (
        input  in_valid, x, pat_load, pat_in,
        output match, pattern_q
    );
endinterface

// File: rtl/seq_detector_moore_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/seq_detector_moore.sv
// Moore serial pattern detector with run-time pattern reload and overlap select.
// Optional match counter (cnt_clr / match_cnt) is built when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_moore
    import seq_det_pkg::*;
#(
    parameter int             PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b101,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_moore_if.slave  bus
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     match_cnt
`endif
);
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if (PAT_W < SEQ_DET_PAT_W_MIN || PAT_W > SEQ_DET_PAT_W_MAX || CNT_W < 1) begin : g_bad_param
        $error("seq_detector_moore: PAT_W must be within 2..16 and CNT_W positive");
    end

    seq_det_state_t    state_q, state_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] nf;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        nh      = {hist_q[PAT_W-2:0], bus.x};
        nf      = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

        // A reload flushes history so a stale prefix can never complete the new pattern.
        if (bus.pat_load) begin
            pat_d   = bus.pat_in;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (bus.in_valid) begin
            hist_d = nh;
            if ((nf == FILL_FULL) && (nh == pat_q)) begin
                state_d = MATCH;
                if (OVERLAP) begin
                    fill_d = FILL_FULL;
                end else begin
                    fill_d = '0;
                    hist_d = '0;
                end
            end else begin
                fill_d  = nf;
                state_d = (nf == FILL_FULL) ? ARMED : FILL;
            end
        end else if (state_q == MATCH) begin
            state_d = (fill_q == FILL_FULL) ? ARMED : FILL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PATTERN;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
        end
    end

    assign bus.match     = (state_q == MATCH);
    assign bus.pattern_q = pat_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic cnt_inc;
    assign cnt_inc = (state_d == MATCH);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (match_cnt)
    );
`endif
endmodule

// File: tb/tb_seq_detector_moore.sv
// Bench for seq_detector_moore: three detector configurations fed the same stream,
// each checked every cycle against a bit-history reference model.
module tb_seq_detector_moore;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_detector_moore_if #(.PAT_W(3)) if_a ();
    seq_detector_moore_if #(.PAT_W(3)) if_b ();
    seq_detector_moore_if #(.PAT_W(4)) if_c ();

`ifdef SEQ_DET_MATCH_CNT_EN
    logic       cnt_clr;
    logic [1:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] cnt_c;
`endif

    seq_detector_moore #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt_a)
`endif
    );

    seq_detector_moore #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt_b)
`endif
    );

    seq_detector_moore #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .bus(if_c)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt_c)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference: number of valid bits seen since the last flush plus their value.
    int W     [3] = '{3, 3, 4};
    bit OV    [3] = '{1'b1, 1'b0, 1'b1};
    int PINIT [3] = '{5, 5, 6};
    int CMAX  [3] = '{3, 255, 255};
    int m_pat [3];
    int m_h   [3];
    int m_n   [3];
    int m_cnt [3];
    bit m_match [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] om [3];
        logic [31:0] op [3];
        om[0] = 32'(if_a.match);     om[1] = 32'(if_b.match);     om[2] = 32'(if_c.match);
        op[0] = 32'(if_a.pattern_q); op[1] = 32'(if_b.pattern_q); op[2] = 32'(if_c.pattern_q);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("match[%0d]", k), om[k], 32'(m_match[k]));
            chk($sformatf("pattern_q[%0d]", k), op[k], 32'(m_pat[k]));
        end
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("match_cnt[0]", 32'(cnt_a), 32'(m_cnt[0]));
        chk("match_cnt[1]", 32'(cnt_b), 32'(m_cnt[1]));
        chk("match_cnt[2]", 32'(cnt_c), 32'(m_cnt[2]));
`endif
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_pat[k] = PINIT[k]; m_h[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_match[k] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input bit xb, input bit ld, input int pa, input int pc, input bit clr);
        int mask, n, pin;
        for (int k = 0; k < 3; k++) begin
            mask = (1 << W[k]) - 1;
            pin  = (k < 2) ? pa : pc;
            m_match[k] = 1'b0;
            if (ld) begin
                m_pat[k] = pin & mask; m_h[k] = 0; m_n[k] = 0;
            end else if (v) begin
                m_h[k] = ((m_h[k] << 1) | int'(xb)) & mask;
                n = (m_n[k] + 1 > W[k]) ? W[k] : m_n[k] + 1;
                if (n == W[k] && m_h[k] == m_pat[k]) begin
                    m_match[k] = 1'b1;
                    if (!OV[k]) begin
                        n = 0; m_h[k] = 0;
                    end
                end
                m_n[k] = n;
            end
            if (clr) m_cnt[k] = 0;
            else if (m_match[k] && m_cnt[k] < CMAX[k]) m_cnt[k]++;
        end
    endtask

    task automatic step(input bit v, input bit xb, input bit ld = 1'b0, input int pa = 0,
                        input int pc = 0, input bit clr = 1'b0);
        @(negedge clk);
        if_a.in_valid = v;  if_b.in_valid = v;  if_c.in_valid = v;
        if_a.x = xb;        if_b.x = xb;        if_c.x = xb;
        if_a.pat_load = ld; if_b.pat_load = ld; if_c.pat_load = ld;
        if_a.pat_in = pa[2:0]; if_b.pat_in = pa[2:0]; if_c.pat_in = pc[3:0];
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_clr = clr;
`endif
        @(posedge clk);
        model_step(v, xb, ld, pa, pc, clr);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
        if_a.pat_load = 1'b0; if_b.pat_load = 1'b0; if_c.pat_load = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();
    endtask

    task automatic send_bits(input int bits [$]);
        foreach (bits[i]) step(1'b1, bits[i][0]);
    endtask

    initial begin
        rst = 1'b0;
        if_a.in_valid = 1'b0; if_b.in_valid = 1'b0; if_c.in_valid = 1'b0;
        if_a.x = 1'b0;        if_b.x = 1'b0;        if_c.x = 1'b0;
        if_a.pat_load = 1'b0; if_b.pat_load = 1'b0; if_c.pat_load = 1'b0;
        if_a.pat_in = '0;     if_b.pat_in = '0;     if_c.pat_in = '0;
`ifdef SEQ_DET_MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        do_reset();

        // Overlapping 1,0,1,0,1: two matches on dut_a, one on the non-overlap dut_b.
        send_bits('{1, 0, 1, 0, 1});
        step(1'b0, 1'b0);

        do_reset();
        send_bits('{1, 0, 1, 0, 1, 1, 0, 1});
        step(1'b0, 1'b0);

        // Idle gaps inside a pattern.
        do_reset();
        send_bits('{1, 0});
        repeat (4) step(1'b0, 1'b1);
        send_bits('{1});
        step(1'b0, 1'b0);

        // Reload dut_c to 1100 while dut_a/b keep 101; in_valid high on the load cycle is ignored.
        do_reset();
        send_bits('{0, 1, 1});
        step(1'b1, 1'b0, 1'b1, 5, 12);
        send_bits('{1, 1, 0, 0, 1, 1, 0});
        step(1'b0, 1'b0);

        // All-ones pattern: consecutive matches back to back.
        step(1'b0, 1'b0, 1'b1, 7, 15);
        send_bits('{1, 1, 1, 1, 1, 1, 0});

        // Reset one bit before completion.
        do_reset();
        send_bits('{1, 0});
        do_reset();
        send_bits('{1});
        step(1'b0, 1'b0);
        send_bits('{0, 1, 1, 0, 1});

        // Five matches to saturate the 2-bit counter, then clear alongside a sixth.
        do_reset();
        send_bits('{1, 0, 1, 0, 1, 0, 1, 0, 1, 0});
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 0, 1'b1);
        step(1'b0, 1'b0);

        // Randomised stream with occasional reloads, clears and resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 3) != 0), 1'($urandom),
                     ($urandom_range(0, 59) == 0),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                     ($urandom_range(0, 49) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
